// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for one shared combinational ALU.
//
// A round-robin arbiter grants one requester while idle. The granted operands
// and opcode are registered and sent to the external ALU for one cycle. The
// ALU result is then registered and returned to the requester that owns the
// operation, and held until that requester takes it. Only one operation is in
// flight at a time.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op        request channel of requester N (N = 0, 1)
//   rspN_valid/ready/data          response channel of requester N
//   alu_a, alu_b, alu_op           registered operands/opcode to the shared ALU
//   alu_o                          combinational ALU result
//   busy                           high while an operation is in flight
module alu_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_o,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              owner_reg;   // requester that owns the in-flight operation
  logic              last_reg;    // requester granted most recently
  logic [DATA_W-1:0] a_reg, b_reg, result_reg;
  logic [OP_W-1:0]   op_reg;

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] grant;
  logic [1:0] rsp_valid;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Grant only while idle and out of reset. A tie goes to the requester that
  // was not served last, so two requesters held valid alternate.
  always_comb begin
    grant = 2'b00;
    if (rst_n && (state_reg == IDLE)) begin
      if (req_valid == 2'b11) begin
        grant = last_reg ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  // Response valid goes only to the owner. Gating with rst_n keeps it low for
  // the whole reset interval, including before the first reset edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_valid[gi] = rst_n && (state_reg == RESP) && (owner_reg == 1'(gi));
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = result_reg;
  assign rsp1_data  = result_reg;
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_op     = op_reg;
  assign busy       = rst_n && (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant != 2'b00) state_next = EXEC;
      EXEC:    state_next = RESP;
      // rsp_ready from the non-owner has no effect here.
      RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;   // requester 0 wins the first tie
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      // grant is non-zero only in IDLE, and a grant implies valid, so this is
      // exactly the accept handshake.
      if (grant != 2'b00) begin
        a_reg     <= grant[1] ? req1_a  : req0_a;
        b_reg     <= grant[1] ? req1_b  : req0_b;
        op_reg    <= grant[1] ? req1_op : req0_op;
        owner_reg <= grant[1];
        last_reg  <= grant[1];
      end
      if (state_reg == EXEC) begin
        result_reg <= alu_o;
      end
    end
  end

endmodule
